// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive and transmit blocks.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick, rounded to nearest, never below 1.
  function automatic int calc_div(input int clk_hz, input int baud, input int os);
    longint den;
    longint q;
    den = longint'(baud) * longint'(os);
    q   = (longint'(clk_hz) + den / 2) / den;
    return (q < 1) ? 1 : int'(q);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick divider: one-cycle tick every DIV clocks; restart realigns so the
// first tick lands DIV cycles after the restart cycle.
module uart_tick_gen #(
  parameter int DIV = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == CW'(DIV - 1)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = !restart && (cnt == CW'(DIV - 1));

endmodule

// File: rtl/uart_rx_oversampled.sv
// Oversampled UART receiver with majority-voted bits and a one-frame output buffer.
// Frame commits one cycle after the last stop-bit vote; a full buffer drops the new frame and pulses overrun.
module uart_rx_oversampled
  import uart_pkg::*;
#(
  parameter int CLK_HZ      = 25_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 9,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 valid,
  input  logic                 ready,
  output logic                 parity_error,
  output logic                 framing_error,
  output logic                 overrun,
  output logic                 busy
);

  localparam int           DIV   = calc_div(CLK_HZ, BAUD_RATE, OVERSAMPLE);
  localparam int           M     = OVERSAMPLE / 2;
  localparam int           SW    = $clog2(OVERSAMPLE);
  localparam int           BW    = $clog2(DATA_BITS + 1);
  localparam parity_mode_t PMODE = parity_mode_t'(2'(PARITY_MODE));

  rx_state_t              state, state_nxt;
  logic                   rx_meta, rxs;
  logic                   tick, restart;
  logic [SW-1:0]          sub;
  logic                   s0, s1, maj;
  logic [BW-1:0]          bit_cnt;
  logic [DATA_BITS-1:0]   shreg;
  logic                   pbad, fbad, commit;
  logic                   mid_tick, sub_wrap, end_tick, data_done, last_stop;

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  uart_tick_gen #(.DIV(DIV)) u_tick (
    .clock  (clock),
    .reset  (reset),
    .restart(restart),
    .tick   (tick)
  );

  assign maj       = (s0 & s1) | (s0 & rxs) | (s1 & rxs);
  assign sub_wrap  = (sub == SW'(OVERSAMPLE - 1));
  assign mid_tick  = tick && (sub == SW'(M + 1));
  assign end_tick  = tick && sub_wrap;
  assign data_done = (bit_cnt == BW'(DATA_BITS));
  assign last_stop = (bit_cnt == BW'(STOP_BITS - 1));
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    restart   = 1'b0;
    case (state)
      IDLE: if (!rxs) begin
        state_nxt = START;
        restart   = 1'b1;
      end
      START: begin
        if (mid_tick && maj) state_nxt = IDLE;
        else if (end_tick)   state_nxt = DATA;
      end
      DATA:   if (end_tick && data_done) state_nxt = (PMODE == PAR_NONE) ? STOP : PARITY;
      PARITY: if (end_tick) state_nxt = STOP;
      // Good frames return to IDLE at mid stop bit so an immediately following start edge is seen.
      STOP:   if (mid_tick && last_stop) state_nxt = (fbad || !maj) ? BREAK : IDLE;
      BREAK:  if (tick && rxs && sub_wrap) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sub     <= '0;
      s0      <= 1'b1;
      s1      <= 1'b1;
      bit_cnt <= '0;
      shreg   <= '0;
      pbad    <= 1'b0;
      fbad    <= 1'b0;
      commit  <= 1'b0;
    end else begin
      commit <= 1'b0;
      if (restart) begin
        sub     <= '0;
        bit_cnt <= '0;
        pbad    <= 1'b0;
        fbad    <= 1'b0;
      end else if (state == BREAK) begin
        // Counts consecutive high ticks; any low sample restarts the count.
        if (!rxs)      sub <= '0;
        else if (tick) sub <= sub_wrap ? '0 : sub + SW'(1);
      end else if (tick) begin
        sub <= sub_wrap ? '0 : sub + SW'(1);
        if (sub == SW'(M - 1)) s0 <= rxs;
        if (sub == SW'(M))     s1 <= rxs;
        if (sub == SW'(M + 1)) begin
          case (state)
            DATA: begin
              shreg   <= {maj, shreg[DATA_BITS-1:1]};
              bit_cnt <= bit_cnt + BW'(1);
            end
            PARITY: pbad <= (^shreg) ^ maj ^ (PMODE == PAR_ODD);
            STOP: begin
              fbad <= fbad | ~maj;
              if (last_stop) begin
                commit <= 1'b1;
                sub    <= '0;
              end else begin
                bit_cnt <= bit_cnt + BW'(1);
              end
            end
            default: ;
          endcase
        end
        if (state == DATA && sub_wrap && data_done) bit_cnt <= '0;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data          <= '0;
      valid         <= 1'b0;
      parity_error  <= 1'b0;
      framing_error <= 1'b0;
      overrun       <= 1'b0;
    end else begin
      overrun <= 1'b0;
      if (commit) begin
        if (!valid || ready) begin
          data          <= shreg;
          parity_error  <= pbad;
          framing_error <= fbad;
          valid         <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Bench for uart_rx_oversampled: four line formats (8N1, 9E1, 8N2, 7O1) driven by a
// bit-level line driver, delivered frames compared against frame-level expectations.
module tb_uart_rx_oversampled;

  localparam int CLK_HZ = 32_000_000;
  localparam int BAUD   = 1_000_000;
  localparam int OS     = 8;
  localparam int BIT    = 32;
  localparam int NBITS [4] = '{8, 9, 8, 7};
  localparam int PAR   [4] = '{0, 1, 0, 2};
  localparam int NSTOP [4] = '{1, 1, 2, 1};

  typedef struct packed {
    logic [1:0] inst;
    logic [8:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  typedef struct {
    int         inst;
    logic [8:0] pay;
    bit         flip;
    logic [1:0] stops;
    logic [8:0] ed;
    logic       epe;
    logic       efe;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  [4];
  logic       rdy [4];
  logic       vld [4];
  logic       pe  [4];
  logic       fe  [4];
  logic       ovr [4];
  logic       bsy [4];
  logic [7:0] d0, d2;
  logic [8:0] d1;
  logic [6:0] d3;
  logic [8:0] dat [4];

  assign dat[0] = {1'b0, d0};
  assign dat[1] = d1;
  assign dat[2] = {1'b0, d2};
  assign dat[3] = {2'b00, d3};

  rec_t got [$];
  int   ovr_cnt [4] = '{0, 0, 0, 0};
  int   n_chk  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_rx_oversampled #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clock(clk), .reset(rst), .rx(rx[0]), .data(d0), .valid(vld[0]), .ready(rdy[0]),
    .parity_error(pe[0]), .framing_error(fe[0]), .overrun(ovr[0]), .busy(bsy[0]));

  uart_rx_oversampled #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(9), .PARITY_MODE(1), .STOP_BITS(1)) u_9e1 (
    .clock(clk), .reset(rst), .rx(rx[1]), .data(d1), .valid(vld[1]), .ready(rdy[1]),
    .parity_error(pe[1]), .framing_error(fe[1]), .overrun(ovr[1]), .busy(bsy[1]));

  uart_rx_oversampled #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clock(clk), .reset(rst), .rx(rx[2]), .data(d2), .valid(vld[2]), .ready(rdy[2]),
    .parity_error(pe[2]), .framing_error(fe[2]), .overrun(ovr[2]), .busy(bsy[2]));

  uart_rx_oversampled #(.CLK_HZ(CLK_HZ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS),
    .DATA_BITS(7), .PARITY_MODE(2), .STOP_BITS(1)) u_7o1 (
    .clock(clk), .reset(rst), .rx(rx[3]), .data(d3), .valid(vld[3]), .ready(rdy[3]),
    .parity_error(pe[3]), .framing_error(fe[3]), .overrun(ovr[3]), .busy(bsy[3]));

  // Every handshake and every overrun pulse, sampled just after the falling edge.
  always @(negedge clk) begin
    #1;
    for (int i = 0; i < 4; i++) begin
      if (vld[i] && rdy[i]) got.push_back('{inst: 2'(i), d: dat[i], pe: pe[i], fe: fe[i]});
      if (ovr[i]) ovr_cnt[i]++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic rec_t mk(input int i, input logic [8:0] d, input logic p, input logic f);
    return '{inst: 2'(i), d: d, pe: p, fe: f};
  endfunction

  task automatic expect_rec(input string nm, input rec_t e);
    rec_t a;
    if (got.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s: no frame delivered, expected data 0x%0h", nm, e.d);
    end else begin
      a = got.pop_front();
      chk({nm, "_inst"}, 32'(a.inst), 32'(e.inst));
      chk({nm, "_data"}, 32'(a.d), 32'(e.d));
      chk({nm, "_perr"}, 32'(a.pe), 32'(e.pe));
      chk({nm, "_ferr"}, 32'(a.fe), 32'(e.fe));
    end
  endtask

  task automatic drive_bit(input int idx, input logic b, input int n);
    rx[idx] = b;
    repeat (n) @(negedge clk);
  endtask

  // Start, data LSB first, optional parity, stop bits; line is left at the last stop value.
  // gbit/goff place a one-clock inverted glitch inside one data bit.
  task automatic send_frame(input int idx, input logic [8:0] pay, input bit flip,
                            input logic [1:0] stops, input int gbit, input int goff);
    logic p;
    p = 1'b0;
    drive_bit(idx, 1'b0, BIT);
    for (int i = 0; i < NBITS[idx]; i++) begin
      p = p ^ pay[i];
      if (i == gbit) begin
        drive_bit(idx, pay[i], goff);
        drive_bit(idx, ~pay[i], 1);
        drive_bit(idx, pay[i], BIT - goff - 1);
      end else begin
        drive_bit(idx, pay[i], BIT);
      end
    end
    if (PAR[idx] != 0) drive_bit(idx, p ^ (PAR[idx] == 2) ^ flip, BIT);
    for (int s = 0; s < NSTOP[idx]; s++) drive_bit(idx, stops[s], BIT);
  endtask

  vec_t tbl [8];
  rec_t exp_q [$];

  initial begin
    for (int i = 0; i < 4; i++) begin
      rx[i]  = 1'b1;
      rdy[i] = 1'b1;
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++)
      chk($sformatf("reset_outputs_%0d", i),
          32'({dat[i], vld[i], pe[i], fe[i], ovr[i], bsy[i]}), 32'd0);

    tbl[0] = '{0, 9'h0A5, 1'b0, 2'b11, 9'h0A5, 1'b0, 1'b0};
    tbl[1] = '{1, 9'h1C3, 1'b0, 2'b11, 9'h1C3, 1'b0, 1'b0};
    tbl[2] = '{1, 9'h1C3, 1'b1, 2'b11, 9'h1C3, 1'b1, 1'b0};
    tbl[3] = '{3, 9'h055, 1'b0, 2'b11, 9'h055, 1'b0, 1'b0};
    tbl[4] = '{3, 9'h02A, 1'b1, 2'b11, 9'h02A, 1'b1, 1'b0};
    tbl[5] = '{0, 9'h000, 1'b0, 2'b10, 9'h000, 1'b0, 1'b1};
    tbl[6] = '{2, 9'h0C3, 1'b0, 2'b11, 9'h0C3, 1'b0, 1'b0};
    tbl[7] = '{1, 9'h0FF, 1'b1, 2'b10, 9'h0FF, 1'b1, 1'b1};
    for (int k = 0; k < 8; k++) begin
      send_frame(tbl[k].inst, tbl[k].pay, tbl[k].flip, tbl[k].stops, -1, 0);
      drive_bit(tbl[k].inst, 1'b1, 2 * BIT);
      expect_rec($sformatf("vec%0d", k), mk(tbl[k].inst, tbl[k].ed, tbl[k].epe, tbl[k].efe));
      chk($sformatf("vec%0d_single", k), 32'(got.size()), 32'd0);
    end

    // Short low pulse: start is rejected by the mid-bit vote.
    drive_bit(0, 1'b0, 3);
    rx[0] = 1'b1;
    chk("glitch_busy_rise", 32'(bsy[0]), 32'd1);
    drive_bit(0, 1'b1, BIT);
    chk("glitch_busy_fall", 32'(bsy[0]), 32'd0);
    chk("glitch_no_frame", 32'(got.size()), 32'd0);

    // One-clock glitch on the middle vote point of bit 3 in 0x00.
    send_frame(0, 9'h000, 1'b0, 2'b11, 3, 20);
    drive_bit(0, 1'b1, BIT);
    expect_rec("midbit_glitch", mk(0, 9'h000, 1'b0, 1'b0));

    // Second stop bit low, then line held low: receiver parks until a full high bit.
    send_frame(2, 9'h03C, 1'b0, 2'b01, -1, 0);
    drive_bit(2, 1'b0, 3 * BIT);
    expect_rec("break_frame", mk(2, 9'h03C, 1'b0, 1'b1));
    chk("break_busy_low_line", 32'(bsy[2]), 32'd1);
    drive_bit(2, 1'b1, BIT / 2);
    chk("break_busy_half_bit", 32'(bsy[2]), 32'd1);
    drive_bit(2, 1'b1, BIT + BIT / 2);
    chk("break_busy_released", 32'(bsy[2]), 32'd0);
    chk("break_no_extra_frame", 32'(got.size()), 32'd0);
    send_frame(2, 9'h055, 1'b0, 2'b11, -1, 0);
    drive_bit(2, 1'b1, BIT);
    expect_rec("after_break", mk(2, 9'h055, 1'b0, 1'b0));

    // Overrun: consumer stalled across two back-to-back frames.
    rdy[0] = 1'b0;
    send_frame(0, 9'h011, 1'b0, 2'b11, -1, 0);
    send_frame(0, 9'h022, 1'b0, 2'b11, -1, 0);
    drive_bit(0, 1'b1, BIT);
    chk("ovr_valid_held", 32'(vld[0]), 32'd1);
    chk("ovr_data_kept", 32'(dat[0]), 32'h11);
    chk("ovr_pulse_count", 32'(ovr_cnt[0]), 32'd1);
    rdy[0] = 1'b1;
    @(negedge clk);
    chk("ovr_valid_drop", 32'(vld[0]), 32'd0);
    expect_rec("ovr_frame", mk(0, 9'h011, 1'b0, 1'b0));
    chk("ovr_single", 32'(got.size()), 32'd0);

    // Reset in the middle of 0x7E while 0x42 sits unconsumed in the buffer.
    rdy[0] = 1'b0;
    send_frame(0, 9'h042, 1'b0, 2'b11, -1, 0);
    drive_bit(0, 1'b1, BIT);
    chk("rst_buffered_valid", 32'(vld[0]), 32'd1);
    drive_bit(0, 1'b0, BIT);
    drive_bit(0, 1'b0, BIT);
    drive_bit(0, 1'b1, BIT);
    drive_bit(0, 1'b1, BIT);
    chk("rst_busy_before", 32'(bsy[0]), 32'd1);
    rst   = 1'b1;
    rx[0] = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_outputs_cleared", 32'({dat[0], vld[0], pe[0], fe[0], ovr[0], bsy[0]}), 32'd0);
    rdy[0] = 1'b1;
    drive_bit(0, 1'b1, BIT);
    chk("rst_frame_lost", 32'(got.size()), 32'd0);
    send_frame(0, 9'h081, 1'b0, 2'b11, -1, 0);
    drive_bit(0, 1'b1, BIT);
    expect_rec("rst_next_frame", mk(0, 9'h081, 1'b0, 1'b0));

    // Randomised frames per format, checked in order against frame-level expectations.
    for (int i = 0; i < 4; i++) begin
      exp_q.delete();
      for (int n = 0; n < 12; n++) begin
        logic [8:0] pay;
        bit         flip;
        logic [1:0] stops;
        logic       fexp;
        int         gb, goff, gap;
        pay   = 9'($urandom) & 9'((1 << NBITS[i]) - 1);
        flip  = (PAR[i] != 0) && ($urandom_range(0, 2) == 0);
        stops = 2'b11;
        if ($urandom_range(0, 4) == 0) stops = (NSTOP[i] == 2) ? 2'($urandom_range(0, 2)) : 2'b10;
        fexp = 1'b0;
        for (int s = 0; s < NSTOP[i]; s++) if (!stops[s]) fexp = 1'b1;
        gb = -1;
        if ($urandom_range(0, 2) == 0) gb = int'($urandom_range(0, NBITS[i] - 1));
        goff = int'($urandom_range(1, BIT - 2));
        send_frame(i, pay, flip, stops, gb, goff);
        exp_q.push_back(mk(i, pay, flip, fexp));
        if (fexp) gap = 2 * BIT;
        else if ($urandom_range(0, 2) == 0) gap = 0;
        else gap = int'($urandom_range(1, BIT));
        drive_bit(i, 1'b1, gap);
      end
      drive_bit(i, 1'b1, 2 * BIT);
      for (int n = 0; n < exp_q.size(); n++)
        expect_rec($sformatf("rand_i%0d_n%0d", i, n), exp_q[n]);
      chk($sformatf("rand_i%0d_extra", i), 32'(got.size()), 32'd0);
      got.delete();
    end

    chk("ovr_total_8n1", 32'(ovr_cnt[0]), 32'd1);
    chk("ovr_total_others", 32'(ovr_cnt[1] + ovr_cnt[2] + ovr_cnt[3]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
